// File: rtl/core_if_pf_pkg.sv
// Shared fetch-stage types: address/instruction words and the prefetch queue entry.
package core_if_pf_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] instr_t;

    localparam logic [5:0] OPCODE_NOP = 6'h15;

    typedef struct packed {
        addr_t  pc;
        instr_t instr;
    } fetch_entry_t;

endpackage

// File: rtl/core_if_fifo.sv
// Synchronous FIFO with flush; head is presented combinationally from storage.
module core_if_fifo #(
    parameter type         T     = logic,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  T                       push_data,
    output T                       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int unsigned AW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [AW-1:0]  wptr_q, wptr_d;
    logic [AW-1:0]  rptr_q, rptr_d;
    logic [AW:0]    count_q, count_d;
    logic           do_push, do_pop;

    always_comb begin
        do_push = push & !flush;
        do_pop  = pop & !flush & !empty;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + AW'(1);
            if (do_pop)  rptr_d = rptr_q + AW'(1);
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= push_data;
    end

    assign head  = mem_q[rptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/core_if_pf.sv
// Prefetching instruction-fetch stage: pipelined Wishbone reads into a queue feeding decode.
module core_if_pf
    import core_if_pf_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        bus_cyc,
    output logic        bus_stb,
    output logic        bus_we,
    output logic [31:0] bus_adr,
    input  logic        bus_stall,
    input  logic        bus_ack,
    input  logic [31:0] bus_dat_so,
    input  logic        if_halt,
    input  logic        set_pc,
    input  logic [31:0] new_pc,
    input  logic        if_ready,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   in_use;
    logic          fifo_push, fifo_pop, fifo_flush, fifo_empty, fifo_full;
    logic          issue, ack_drop, ack_push;
    fetch_entry_t  push_entry, head_entry;

    // Bus request and decode-side outputs; rst gating keeps stb low while held in reset.
    always_comb begin
        in_use   = {1'b0, fifo_count} + {1'b0, out_q};
        bus_stb  = rst & !if_halt & !set_pc & !fifo_full & (in_use < (CW+1)'(DEPTH));
        bus_cyc  = bus_stb | (out_q != '0) | (drop_q != '0);
        bus_we   = 1'b0;
        bus_adr  = fetch_pc_q;
        if_valid = !fifo_empty & !if_halt;
        if_pc    = if_valid ? head_entry.pc : resp_pc_q;
        if_instr = if_valid ? head_entry.instr : {OPCODE_NOP, 26'd0};
    end

    always_comb begin
        issue      = bus_stb & !bus_stall;
        ack_drop   = bus_ack & (drop_q != '0);
        ack_push   = bus_ack & (drop_q == '0) & (out_q != '0);
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        out_d      = out_q;
        drop_d     = drop_q;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        push_entry = '{pc: resp_pc_q, instr: bus_dat_so};
        if (set_pc) begin
            // Everything still owed by the bus becomes a discard, minus this cycle's ack.
            fifo_flush = 1'b1;
            fetch_pc_d = new_pc;
            resp_pc_d  = new_pc;
            out_d      = '0;
            drop_d     = drop_q + out_q - CW'(ack_drop | ack_push);
        end else begin
            if (issue) fetch_pc_d = fetch_pc_q + 32'd4;
            if (ack_drop) drop_d = drop_q - CW'(1);
            if (ack_push) begin
                fifo_push = 1'b1;
                resp_pc_d = resp_pc_q + 32'd4;
            end
            out_d    = out_q + CW'(issue) - CW'(ack_push);
            fifo_pop = if_valid & if_ready;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
        end
    end

    core_if_fifo #(
        .T     (fetch_entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .push_data (push_entry),
        .head      (head_entry),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule
